// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared ALU types and width defaults
package alu_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } mul_state_t;

    localparam int DEFAULT_WIDTH = 32;

endpackage

// File: rtl/adderNbit.sv
// rtl/adderNbit.sv - N-bit ripple-carry adder with carry in/out
module adderNbit #(
    parameter int N = 32
) (
    input  logic [N-1:0] a_i,
    input  logic [N-1:0] b_i,
    input  logic         c_i,
    output logic [N-1:0] s_o,
    output logic         c_o
);

    logic [N:0] w_carry;

    assign w_carry[0] = c_i;

    for (genvar i = 0; i < N; i++) begin : g_bit
        assign s_o[i]         = a_i[i] ^ b_i[i] ^ w_carry[i];
        assign w_carry[i + 1] = (a_i[i] & b_i[i]) | (w_carry[i] & (a_i[i] ^ b_i[i]));
    end

    assign c_o = w_carry[N];

endmodule

// File: rtl/shift_add_multiplier.sv
// rtl/shift_add_multiplier.sv - sequential radix-2 shift-and-add N x N -> 2N multiplier
module shift_add_multiplier
    import alu_pkg::*;
#(
    parameter  int N     = DEFAULT_WIDTH,
    localparam int CNT_W = $clog2(N) + 1
) (
    input  logic           clk_i,
    input  logic           rst_ni,
    input  logic           valid_i,
    output logic           ready_o,
    input  logic [N-1:0]   a_i,
    input  logic [N-1:0]   b_i,
    output logic           valid_o,
    input  logic           ready_i,
    output logic [2*N-1:0] product_o,
    output logic           busy_o
);

    mul_state_t       r_state;
    logic [N-1:0]     r_acc_hi;
    logic [N-1:0]     r_acc_lo;
    logic [N-1:0]     r_mcand;
    logic [CNT_W-1:0] r_cnt;

    logic [N-1:0]     w_add_b;
    logic [N-1:0]     w_sum;
    logic             w_cout;

    // acc_lo doubles as the multiplier: its LSB selects the partial product each cycle
    assign w_add_b = r_acc_lo[0] ? r_mcand : '0;

    adderNbit #(.N(N)) u_adder (
        .a_i (r_acc_hi),
        .b_i (w_add_b),
        .c_i (1'b0),
        .s_o (w_sum),
        .c_o (w_cout)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state  <= IDLE;
            r_acc_hi <= '0;
            r_acc_lo <= '0;
            r_mcand  <= '0;
            r_cnt    <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (valid_i) begin
                        r_mcand  <= a_i;
                        r_acc_lo <= b_i;
                        r_acc_hi <= '0;
                        r_cnt    <= '0;
                        r_state  <= RUN;
                    end
                end
                RUN: begin
                    // carry-out lands in the MSB so the 2N-bit result cannot overflow
                    {r_acc_hi, r_acc_lo} <= {w_cout, w_sum, r_acc_lo[N-1:1]};
                    r_cnt                <= r_cnt + CNT_W'(1);
                    if (r_cnt == CNT_W'(N - 1)) begin
                        r_state <= DONE;
                    end
                end
                DONE: begin
                    if (ready_i) begin
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign ready_o   = (r_state == IDLE);
    assign busy_o    = (r_state == RUN);
    assign valid_o   = (r_state == DONE);
    assign product_o = (r_state == DONE) ? {r_acc_hi, r_acc_lo} : '0;

endmodule

// File: tb/tb_shift_add_multiplier.sv
// tb/tb_shift_add_multiplier.sv - scoreboard bench for shift_add_multiplier
module tb_shift_add_multiplier;

    localparam int N = 32;

    logic           clk_i = 1'b0;
    logic           rst_ni;
    logic           valid_i;
    logic           ready_o;
    logic [N-1:0]   a_i;
    logic [N-1:0]   b_i;
    logic           valid_o;
    logic           ready_i;
    logic [2*N-1:0] product_o;
    logic           busy_o;

    shift_add_multiplier #(.N(N)) dut (
        .clk_i     (clk_i),
        .rst_ni    (rst_ni),
        .valid_i   (valid_i),
        .ready_o   (ready_o),
        .a_i       (a_i),
        .b_i       (b_i),
        .valid_o   (valid_o),
        .ready_i   (ready_i),
        .product_o (product_o),
        .busy_o    (busy_o)
    );

    always #5 clk_i = ~clk_i;

    logic [63:0] exp_q[$];
    int n_vec    = 0;
    int n_err    = 0;
    int n_issued = 0;
    int n_popped = 0;
    bit rnd_ready   = 1'b0;
    bit ready_force = 1'b1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    // Downstream ready: either forced by the directed tests or randomized.
    always @(posedge clk_i) begin
        #1;
        ready_i = rnd_ready ? ($urandom_range(0, 3) != 0) : ready_force;
    end

    // Monitor: every presented result must match the oldest outstanding product.
    always @(negedge clk_i) begin
        if (rst_ni === 1'b1 && valid_o === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL unexpected_result: got %0h with nothing outstanding", product_o);
            end else begin
                check("product", product_o, exp_q[0]);
                if (ready_i === 1'b1) begin
                    void'(exp_q.pop_front());
                    n_popped++;
                end
            end
        end
    end

    task automatic issue(input logic [31:0] a, input logic [31:0] b, output int waits);
        bit ok;
        ok      = 1'b0;
        waits   = 0;
        a_i     = a;
        b_i     = b;
        valid_i = 1'b1;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk_i);
            if (ready_o === 1'b1) begin
                ok = 1'b1;
                break;
            end
            waits++;
            @(posedge clk_i);
            #1;
        end
        if (!ok) begin
            check("accept_timeout", 64'(ready_o), 64'd1);
            valid_i = 1'b0;
        end else begin
            @(posedge clk_i);
            exp_q.push_back(64'(a) * 64'(b));
            n_issued++;
            #1;
            valid_i = 1'b0;
            a_i     = $urandom;
            b_i     = $urandom;
        end
    endtask

    task automatic wait_valid(output int lat, output int nrdy, output int nbusy);
        lat   = 0;
        nrdy  = 0;
        nbusy = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk_i);
            lat++;
            if (ready_o !== 1'b0) nrdy++;
            if (valid_o === 1'b1) break;
            if (busy_o === 1'b1) nbusy++;
        end
        if (valid_o !== 1'b1) check("valid_timeout", 64'(valid_o), 64'd1);
    endtask

    function automatic logic [31:0] rand_op();
        int sel;
        sel = $urandom_range(0, 7);
        if (sel == 0) return 32'd0;
        if (sel == 1) return 32'hFFFF_FFFF;
        return $urandom;
    endfunction

    logic [31:0] dir_a[3] = '{32'hFFFF_FFFF, 32'd0, 32'd1};
    logic [31:0] dir_b[3] = '{32'hFFFF_FFFF, 32'hDEAD_BEEF, 32'hDEAD_BEEF};

    initial begin
        int w, lat, nrdy, nbusy, gap;
        rst_ni  = 1'b0;
        valid_i = 1'b0;
        ready_i = 1'b0;
        a_i     = '0;
        b_i     = '0;
        #2;
        check("reset_ready_o", 64'(ready_o), 64'd1);
        check("reset_valid_o", 64'(valid_o), 64'd0);
        check("reset_busy_o", 64'(busy_o), 64'd0);
        check("reset_product_o", product_o, 64'd0);
        repeat (2) @(posedge clk_i);
        #1;
        rst_ni = 1'b1;

        // Basic: 3 x 5 with latency and ready/busy profile
        issue(32'd3, 32'd5, w);
        wait_valid(lat, nrdy, nbusy);
        check("latency_basic", 64'(lat), 64'd33);
        check("ready_low_run_done", 64'(nrdy), 64'd0);
        check("busy_cycles", 64'(nbusy), 64'(N));

        // Max, zero, one operands
        for (int k = 0; k < 3; k++) begin
            @(posedge clk_i);
            #1;
            issue(dir_a[k], dir_b[k], w);
            wait_valid(lat, nrdy, nbusy);
            check("latency_corner", 64'(lat), 64'd33);
        end

        // Backpressure: hold result 10 cycles while a new request waits
        ready_force = 1'b0;
        @(posedge clk_i);
        #1;
        issue(32'd7, 32'd9, w);
        wait_valid(lat, nrdy, nbusy);
        a_i     = 32'd11;
        b_i     = 32'd13;
        valid_i = 1'b1;
        for (int i = 0; i < 10; i++) begin
            if (i > 0) @(negedge clk_i);
            check("hold_valid_o", 64'(valid_o), 64'd1);
            check("hold_product_o", product_o, 64'd63);
            check("hold_ready_o", 64'(ready_o), 64'd0);
        end
        ready_force = 1'b1;
        @(posedge clk_i);
        #1;
        issue(32'd11, 32'd13, w);
        check("reaccept_wait", 64'(w), 64'd1);
        wait_valid(lat, nrdy, nbusy);
        check("latency_after_hold", 64'(lat), 64'd33);

        // Reset in RUN cycle 12
        @(posedge clk_i);
        #1;
        issue(32'd100, 32'd200, w);
        repeat (12) @(negedge clk_i);
        rst_ni = 1'b0;
        #1;
        check("midrun_ready_o", 64'(ready_o), 64'd1);
        check("midrun_valid_o", 64'(valid_o), 64'd0);
        check("midrun_busy_o", 64'(busy_o), 64'd0);
        check("midrun_product_o", product_o, 64'd0);
        n_issued -= exp_q.size();
        exp_q.delete();
        @(posedge clk_i);
        #1;
        rst_ni      = 1'b1;
        ready_force = 1'b0;
        @(posedge clk_i);
        #1;
        issue(32'd2, 32'd3, w);
        wait_valid(lat, nrdy, nbusy);
        check("latency_after_reset", 64'(lat), 64'd33);

        // Reset while holding in DONE: valid_o must drop immediately
        rst_ni = 1'b0;
        #1;
        check("middone_valid_o", 64'(valid_o), 64'd0);
        check("middone_product_o", product_o, 64'd0);
        n_issued -= exp_q.size();
        exp_q.delete();
        @(posedge clk_i);
        #1;
        rst_ni      = 1'b1;
        ready_force = 1'b1;

        // Randomized back-to-back traffic
        rnd_ready = 1'b1;
        for (int k = 0; k < 1000; k++) begin
            gap = $urandom_range(0, 3);
            repeat (gap) @(posedge clk_i);
            #1;
            issue(rand_op(), rand_op(), w);
        end
        for (int i = 0; i < 500; i++) begin
            if (exp_q.size() == 0) break;
            @(posedge clk_i);
        end
        @(negedge clk_i);
        check("drain_outstanding", 64'(exp_q.size()), 64'd0);
        check("result_count", 64'(n_popped), 64'(n_issued));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
